// File: rtl/array_div_seq.sv
//------------------------------------------------------------------------------
// Module   : array_div_seq
// Function : Sequential 8-bit / 4-bit unsigned restoring divider. The quotient
//            is developed MSB-first, one bit per cycle, over 8 cycles. Results
//            satisfy dividend = quotient * divisor + remainder.
// Options  : DIV_ZERO_CHECK_EN - when defined, a zero divisor completes at once
//            (quotient 0xFF, remainder dividend[3:0]) and sets div_by_zero.
//            When undefined, div_by_zero is tied low and a zero divisor runs
//            the normal 8-step path.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module array_div_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic [7:0] quotient,
  output logic [3:0] remainder,
  output logic       busy,
  output logic       done,
  output logic       div_by_zero
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [2:0] c_LAST_STEP = 3'd7;

  state_t     r_state;
  logic [7:0] r_dvd;   // dividend bits shift out of the top, quotient bits in at the bottom
  logic [3:0] r_dvs;   // captured divisor
  logic [3:0] r_rem;   // partial remainder
  logic [2:0] r_cnt;   // step counter

  logic [4:0] w_trial;
  logic       w_qbit;
  logic [3:0] w_rem_next;

  // One restoring step: bring down the next dividend bit and subtract if it fits.
  // The subtraction is done modulo 16 because the true result is always < divisor.
  always_comb begin
    w_trial    = {r_rem, r_dvd[7]};
    w_qbit     = (w_trial >= {1'b0, r_dvs});
    w_rem_next = w_trial[3:0] - (w_qbit ? r_dvs : 4'd0);
  end

  // Control FSM, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_dvd     <= 8'd0;
      r_dvs     <= 4'd0;
      r_rem     <= 4'd0;
      r_cnt     <= 3'd0;
      quotient  <= 8'd0;
      remainder <= 4'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef DIV_ZERO_CHECK_EN
      div_by_zero <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
`ifdef DIV_ZERO_CHECK_EN
            if (divisor == 4'd0) begin
              // Zero divisor finishes immediately with the saturated result.
              quotient    <= 8'hFF;
              remainder   <= dividend[3:0];
              div_by_zero <= 1'b1;
              done        <= 1'b1;
            end else
`endif
            begin
              r_state <= S_RUN;
              busy    <= 1'b1;
              r_dvd   <= dividend;
              r_dvs   <= divisor;
              r_rem   <= 4'd0;
              r_cnt   <= 3'd0;
            end
          end
        end
        S_RUN: begin
          r_rem <= w_rem_next;
          r_dvd <= {r_dvd[6:0], w_qbit};
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == c_LAST_STEP) begin
            r_state   <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= {r_dvd[6:0], w_qbit};
            remainder <= w_rem_next;
`ifdef DIV_ZERO_CHECK_EN
            div_by_zero <= 1'b0;
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifndef DIV_ZERO_CHECK_EN
  assign div_by_zero = 1'b0;
`endif

endmodule

`default_nettype wire
